// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared widths and constants for the PWM peripheral
package pwm_pkg;
   localparam int         PWM_CNT_W            = 8;
   localparam logic [7:0] DUTY_FULL            = 8'hFF;
   localparam int         PRESCALE_DIV_DEFAULT = 3000;
   localparam int         OUT_W                = 16;

   // Full-scale duty is forced high so the 255->0 wrap never glitches low.
   function automatic logic pwm_level_f(input logic [PWM_CNT_W-1:0] cnt,
                                        input logic [PWM_CNT_W-1:0] duty);
      return (duty == DUTY_FULL) || (cnt < duty);
   endfunction
endpackage

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - prescaler, 8-bit PWM counter and period_start pulse
module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int PRESCALE_DIV = PRESCALE_DIV_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic [PWM_CNT_W-1:0] pwm_cnt,
   output logic                 wrap,
   output logic                 period_start
);
   logic                 tick;
   logic [PWM_CNT_W-1:0] pwm_cnt_q, pwm_cnt_d;
   logic                 period_start_q, period_start_d;

   generate
      if (PRESCALE_DIV == 1) begin : g_no_presc
         assign tick = 1'b1;
      end else begin : g_presc
         localparam int PW = $clog2(PRESCALE_DIV);
         logic [PW-1:0] presc_q, presc_d;

         assign tick = (presc_q == PW'(PRESCALE_DIV - 1));

         always_comb begin
            presc_d = presc_q + 1'b1;
            if (tick) presc_d = '0;
         end

         always_ff @(posedge clk) begin
            if (rst) presc_q <= '0;
            else     presc_q <= presc_d;
         end
      end
   endgenerate

   always_comb begin
      wrap           = tick && (pwm_cnt_q == '1);
      pwm_cnt_d      = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
      period_start_d = wrap;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_cnt_q      <= '0;
         period_start_q <= 1'b0;
      end else begin
         pwm_cnt_q      <= pwm_cnt_d;
         period_start_q <= period_start_d;
      end
   end

   assign pwm_cnt      = pwm_cnt_q;
   assign period_start = period_start_q;
endmodule

// File: rtl/pwm_peripheral.sv
// rtl/pwm_peripheral.sv - 16-pin PWM/GPIO output block
// PWM_DUTY_SHADOW_EN: latch duty only at the period wrap.
module pwm_peripheral
   import pwm_pkg::*;
#(
   parameter int PRESCALE_DIV = PRESCALE_DIV_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  en_reg_out_7_0,
   input  logic [7:0]  en_reg_out_15_8,
   input  logic [7:0]  en_reg_pwm_7_0,
   input  logic [7:0]  en_reg_pwm_15_8,
   input  logic [7:0]  pwm_duty_cycle,
   output logic [15:0] out,
   output logic        period_start
);
   logic [PWM_CNT_W-1:0] pwm_cnt;
   logic                 wrap;
   logic [PWM_CNT_W-1:0] duty_act;
   logic                 pwm_level;
   logic [OUT_W-1:0]     en_out, en_pwm;
   logic [OUT_W-1:0]     out_q, out_d;

   pwm_timebase #(.PRESCALE_DIV(PRESCALE_DIV)) u_timebase (
      .clk          (clk),
      .rst          (rst),
      .pwm_cnt      (pwm_cnt),
      .wrap         (wrap),
      .period_start (period_start)
   );

`ifdef PWM_DUTY_SHADOW_EN
   logic [PWM_CNT_W-1:0] duty_act_q, duty_act_d;

   always_comb begin
      duty_act_d = duty_act_q;
      if (wrap) duty_act_d = pwm_duty_cycle;
   end

   always_ff @(posedge clk) begin
      if (rst) duty_act_q <= '0;
      else     duty_act_q <= duty_act_d;
   end

   assign duty_act = duty_act_q;
`else
   logic unused_wrap;
   assign unused_wrap = wrap;
   assign duty_act    = pwm_duty_cycle;
`endif

   always_comb begin
      en_out    = {en_reg_out_15_8, en_reg_out_7_0};
      en_pwm    = {en_reg_pwm_15_8, en_reg_pwm_7_0};
      pwm_level = pwm_level_f(pwm_cnt, duty_act);
      out_d     = en_out & (~en_pwm | {OUT_W{pwm_level}});
   end

   always_ff @(posedge clk) begin
      if (rst) out_q <= '0;
      else     out_q <= out_d;
   end

   assign out = out_q;
endmodule

// File: tb/tb_pwm_peripheral.sv
// tb/tb_pwm_peripheral.sv - randomized bench for pwm_peripheral against a cycle-count model
module tb_pwm_peripheral;
   localparam int DIV    = 4;
   localparam int PERIOD = 256 * DIV;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] en_out, en_pwm;
   logic [7:0]  duty;
   logic [15:0] out;
   logic        period_start;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference state: clock edges since reset released, and the duty latched at the last wrap.
   int         n_edges;
   logic [7:0] duty_sh;

   pwm_peripheral #(.PRESCALE_DIV(DIV)) dut (
      .clk             (clk),
      .rst             (rst),
      .en_reg_out_7_0  (en_out[7:0]),
      .en_reg_out_15_8 (en_out[15:8]),
      .en_reg_pwm_7_0  (en_pwm[7:0]),
      .en_reg_pwm_15_8 (en_pwm[15:8]),
      .pwm_duty_cycle  (duty),
      .out             (out),
      .period_start    (period_start)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      logic [15:0] exp_out;
      logic        exp_ps;
      logic [7:0]  da;
      int          cnt_pre;
      logic        lvl;
      if (rst) begin
         n_edges = 0;
         duty_sh = 8'h00;
         exp_out = 16'h0000;
         exp_ps  = 1'b0;
      end else begin
         cnt_pre = (n_edges / DIV) % 256;
`ifdef PWM_DUTY_SHADOW_EN
         da = duty_sh;
`else
         da = duty;
`endif
         lvl = (da == 8'hFF) ? 1'b1 : (cnt_pre < int'(da));
         for (int i = 0; i < 16; i++)
            exp_out[i] = !en_out[i] ? 1'b0 : (!en_pwm[i] ? 1'b1 : lvl);
         n_edges++;
         exp_ps = (n_edges % PERIOD == 0);
         if (exp_ps) duty_sh = duty;
      end
      @(posedge clk);
      #1;
      check("out", out, exp_out);
      check("period_start", period_start, exp_ps);
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) step();
   endtask

   // Waits for period_start, then counts out[0] highs over one full period.
   task automatic measure(input int change_at, input logic [7:0] new_duty, output int highs);
      int k = 0;
      while (period_start !== 1'b1 && k < PERIOD + 16) begin
         step();
         k++;
      end
      if (period_start !== 1'b1) check("ps_timeout", 0, 1);
      highs = 0;
      for (int i = 0; i < PERIOD; i++) begin
         if (i == change_at) duty = new_duty;
         step();
         highs += int'(out[0]);
      end
      check("period_len", period_start, 1);
   endtask

   initial begin
      int h, h1, h2, k;
      logic [7:0] r;
      rst = 1'b1; en_out = '0; en_pwm = '0; duty = 8'h80;
      n_edges = 0; duty_sh = '0;
      run(2);
      check("rst_out", out, 16'h0000);
      check("rst_ps", period_start, 0);
      rst = 1'b0;

      run(2 * PERIOD);

      en_out = 16'hFFFF; en_pwm = 16'h0000;
      step();
      check("gpio_high", out, 16'hFFFF);
      run(100);

      en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'h80;
      step();
      measure(-1, 8'h00, h);
      measure(-1, 8'h00, h);
      check("duty80_highs", h, 512);

      duty = 8'h00; step();
      measure(-1, 8'h00, h);
      check("duty00_highs", h, 0);
      duty = 8'hFF; step();
      measure(-1, 8'h00, h);
      check("dutyFF_highs", h, PERIOD);

      duty = 8'h40; step();
      measure(-1, 8'h00, h);
      check("duty40_highs", h, 256);
      measure(10 * DIV, 8'hC0, h1);
      measure(-1, 8'h00, h2);
`ifdef PWM_DUTY_SHADOW_EN
      check("shadow_cur_period", h1, 256);
`else
      check("noshadow_cur_period", h1, 768);
`endif
      check("next_period", h2, 768);

      duty = 8'h80;
      run(100 * DIV);
      rst = 1'b1;
      step();
      check("midrst_out", out, 16'h0000);
      rst = 1'b0;
      k = 0;
      do begin
         step();
         k++;
      end while (period_start !== 1'b1 && k < PERIOD + 16);
      check("rst_restart_len", k, PERIOD);

      for (int seg = 0; seg < 40; seg++) begin
         en_out = 16'($urandom);
         en_pwm = 16'($urandom);
         r = 8'($urandom);
         case ($urandom_range(0, 3))
            0: duty = 8'h00;
            1: duty = 8'hFF;
            default: duty = r;
         endcase
         if ($urandom_range(0, 9) == 0) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
         end
         run($urandom_range(1, 300));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/pwm_peripheral.md
PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

Interface
REQ-001 The block SHALL have parameter PRESCALE_DIV, default 3000, the number of clk cycles per PWM counter step (legal range 1..65535).
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port en_reg_out_7_0, input, 8 bits: output enable for out[7:0].
REQ-005 The block SHALL have port en_reg_out_15_8, input, 8 bits: output enable for out[15:8].
REQ-006 The block SHALL have port en_reg_pwm_7_0, input, 8 bits: PWM mode select for out[7:0].
REQ-007 The block SHALL have port en_reg_pwm_15_8, input, 8 bits: PWM mode select for out[15:8].
REQ-008 The block SHALL have port pwm_duty_cycle, input, 8 bits: duty value shared by all PWM-mode outputs.
REQ-009 The block SHALL have port out, output, 16 bits: registered output pins.
REQ-010 The block SHALL have port period_start, output, 1 bit: one-cycle pulse at each PWM period start.

Function
REQ-011 Prescaler SHALL count 0..PRESCALE_DIV-1 and then wrap to 0; tick is asserted during the cycle in which prescaler == PRESCALE_DIV-1.
REQ-012 The 8-bit pwm_cnt SHALL increment on each tick and wrap 255->0; one period is therefore 256*PRESCALE_DIV clk cycles.
REQ-013 period_start SHALL be high for exactly the one cycle after pwm_cnt wraps 255->0, and low at all other times.
REQ-014 duty_act (effective duty) SHALL be as given in REQ-026/REQ-027; pwm_level = 1 if duty_act == 8'hFF, else (pwm_cnt < duty_act).
REQ-015 Duty 8'h00 SHALL give a constantly low pwm_level; duty 8'hFF SHALL give a constantly high pwm_level (100%, no glitch at wrap).
REQ-016 Per bit i, next out[i] SHALL be: 0 if out-enable bit i is 0; 1 if out-enable is 1 and pwm-select is 0; pwm_level if both are 1.
REQ-017 out SHALL be registered, reflecting enable/select/pwm_cnt state with exactly one clk cycle latency.
REQ-018 Enable or select changes SHALL take effect on the next clk edge regardless of PWM phase; only duty is subject to shadowing.
REQ-019 With PRESCALE_DIV == 1, tick SHALL be asserted every cycle with no prescaler storage required.

Reset
REQ-020 With rst high at a clk edge, prescaler, pwm_cnt and duty_act SHALL become 0 and out SHALL become 16'h0000.
REQ-021 period_start SHALL be 0 during and in the first cycle after reset.
REQ-022 Reset asserted mid-period SHALL abandon the period; counting SHALL restart from prescaler=0, pwm_cnt=0 on the first cycle with rst low.
REQ-023 The first period after reset SHALL NOT produce a period_start pulse at its start; the first pulse SHALL occur at the first 255->0 wrap.

Configuration
REQ-024 The block SHALL honour macro PWM_DUTY_SHADOW_EN.
REQ-025 The block SHALL NOT differ in port list or parameters with or without the macro.
REQ-026 With PWM_DUTY_SHADOW_EN defined, duty_act SHALL load pwm_duty_cycle only on the cycle pwm_cnt wraps 255->0 (and 0 on reset), so no period is truncated.
REQ-027 Without PWM_DUTY_SHADOW_EN, duty_act SHALL equal pwm_duty_cycle combinationally (immediate update, mid-period glitches allowed).

Structure
REQ-028 Package pwm_pkg SHALL hold PWM_CNT_W=8, DUTY_FULL=8'hFF, PRESCALE_DIV_DEFAULT=3000 and the out width 16.
REQ-029 Sub-module pwm_timebase SHALL contain the prescaler, pwm_cnt and period_start generation, exporting pwm_cnt and wrap.
REQ-030 pwm_peripheral SHALL instantiate pwm_timebase and contain the duty shadow, comparator and output mux.

Verification (bench uses PRESCALE_DIV=4, period 1024 clk cycles)
REQ-031 Reset, then all enables 0 and duty 8'h80 -> out stays 16'h0000 for 2 periods.
REQ-032 en_out=16'hFFFF, en_pwm=0 -> out becomes 16'hFFFF one cycle later and stays there.
REQ-033 en_out=en_pwm=16'h0001 with duty 8'h80 -> out[0] high 512 of every 1024 cycles, other bits 0, period_start every 1024 cycles.
REQ-034 Duty 8'h00 then 8'hFF, out[0] in PWM mode -> constant 0 then constant 1 across a full period including the wrap.
REQ-035 Shadow on: duty changes 8'h40->8'hC0 at pwm_cnt=10 -> current period high 256 cycles, next period high 768 cycles; macro off -> change visible within one cycle.
REQ-036 rst pulsed for 1 cycle at pwm_cnt=100 -> out=0, counters restart at 0, next period_start exactly 1024 cycles after rst deasserts.
